bus_move_ctrl: RTL and testbench

Bus-side controller for the shared 8-bit data bus. It is the initiator that drives the per-register output-enable and write strobes, so a single request performs one register-to-register (or immediate-to-register) transfer. It sits between the instruction decoder and the register bank. It guarantees one driver on the bus at a time and exactly one write strobe per transfer.

---
 rtl/bus_move_ctrl_if.sv | 39 +++
 rtl/bus_move_ctrl.sv | 171 +++++++++++++++++
 tb/tb_bus_move_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bus_move_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_move_ctrl_if
// Purpose  : Request and bus-strobe bundle between decoder, bus_move_ctrl and
//            the register bank.
// Revision : 1.0  initial release
// ============================================================================
interface bus_move_ctrl_if #(
   parameter int NUM_REGS = 8,
   parameter int SEL_W    = 3
) ();
   logic                req;
   logic                src_imm;
   logic [SEL_W-1:0]    src;
   logic [SEL_W-1:0]    dst;
   logic [7:0]          imm;
   logic                ready;
   logic                done;
   logic                err;
   logic [NUM_REGS-1:0] enable;
   logic [NUM_REGS-1:0] write;
   logic [7:0]          bus_out;
   logic                bus_oe;
   logic [7:0]          bus_in;
   logic [7:0]          last_data;

   // Controller side.
   modport slave (
      input  req, src_imm, src, dst, imm, bus_in,
      output ready, done, err, enable, write, bus_out, bus_oe, last_data
   );

   // Decoder / bus-fabric side.
   modport master (
      output req, src_imm, src, dst, imm, bus_in,
      input  ready, done, err, enable, write, bus_out, bus_oe, last_data
   );
endinterface
`default_nettype wire

// File: rtl/bus_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_move_ctrl
// Purpose  : Shared 8-bit bus transfer initiator: one request moves a register
//            or immediate into a register with a single write strobe.
// Options  : BUS_MOVE_CTRL_VERIFY_EN adds a destination readback cycle.
// Revision : 1.0  initial release
// ============================================================================
module bus_move_ctrl #(
   parameter int NUM_REGS = 8,
   parameter int SEL_W    = 3
) (
   input  wire logic          clk,
   input  wire logic          reset,
   bus_move_ctrl_if.slave     bif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_LATCH  = 3'd2,
      S_VERIFY = 3'd3,
      S_DONE   = 3'd4,
      S_FAIL   = 3'd5
   } state_t;

   localparam logic [NUM_REGS-1:0] c_ONE_HOT_LSB = {{(NUM_REGS-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic                r_src_imm;
   logic [SEL_W-1:0]    r_src;
   logic [SEL_W-1:0]    r_dst;
   logic [7:0]          r_imm;
   logic                r_ready;
   logic                r_done;
   logic                r_err;
   logic [NUM_REGS-1:0] r_enable;
   logic [NUM_REGS-1:0] r_write;
   logic [7:0]          r_bus_out;
   logic                r_bus_oe;
   logic [7:0]          r_last_data;

   state_t              w_next;
   logic                w_accept;
   logic                w_illegal;
   logic                w_src_imm;
   logic [SEL_W-1:0]    w_src;
   logic [SEL_W-1:0]    w_dst;
   logic [7:0]          w_imm;
   logic                w_vfy_mismatch;
   logic                w_ready;
   logic                w_done;
   logic                w_err;
   logic [NUM_REGS-1:0] w_enable;
   logic [NUM_REGS-1:0] w_write;
   logic [7:0]          w_bus_out;
   logic                w_bus_oe;

   assign w_accept = (r_state == S_IDLE) && bif.req;

   // Outputs are decoded from the next state, so on the accept edge the
   // request fields come straight from the inputs rather than the latches.
   assign w_src_imm = (r_state == S_IDLE) ? bif.src_imm : r_src_imm;
   assign w_src     = (r_state == S_IDLE) ? bif.src     : r_src;
   assign w_dst     = (r_state == S_IDLE) ? bif.dst     : r_dst;
   assign w_imm     = (r_state == S_IDLE) ? bif.imm     : r_imm;

   assign w_illegal = (!bif.src_imm && (bif.src == bif.dst))
                   || (!bif.src_imm && (32'(bif.src) >= NUM_REGS))
                   || (32'(bif.dst) >= NUM_REGS);

   always_comb begin
      w_next         = r_state;
      w_vfy_mismatch = 1'b0;
      case (r_state)
         S_IDLE:   if (bif.req) w_next = w_illegal ? S_FAIL : S_DRIVE;
         S_DRIVE:  w_next = S_LATCH;
`ifdef BUS_MOVE_CTRL_VERIFY_EN
         S_LATCH:  w_next = S_VERIFY;
`else
         S_LATCH:  w_next = S_DONE;
`endif
         S_VERIFY: begin
            w_next         = S_DONE;
            w_vfy_mismatch = (bif.bus_in != r_last_data);
         end
         S_DONE:   w_next = S_IDLE;
         S_FAIL:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ready   = 1'b0;
      w_done    = 1'b0;
      w_err     = 1'b0;
      w_enable  = '0;
      w_write   = '0;
      w_bus_out = 8'h00;
      w_bus_oe  = 1'b0;
      case (w_next)
         S_IDLE:   w_ready = 1'b1;
         S_DRIVE, S_LATCH: begin
            // Exactly one bus driver: the immediate port or one register.
            if (w_src_imm) begin
               w_bus_oe  = 1'b1;
               w_bus_out = w_imm;
            end else begin
               w_enable  = c_ONE_HOT_LSB << w_src;
            end
            if (w_next == S_LATCH) w_write = c_ONE_HOT_LSB << w_dst;
         end
         S_VERIFY: w_enable = c_ONE_HOT_LSB << w_dst;
         S_DONE: begin
            w_done = 1'b1;
            w_err  = w_vfy_mismatch;
         end
         S_FAIL: begin
            w_done = 1'b1;
            w_err  = 1'b1;
         end
         default:  w_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_src_imm   <= 1'b0;
         r_src       <= '0;
         r_dst       <= '0;
         r_imm       <= 8'h00;
         r_ready     <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_enable    <= '0;
         r_write     <= '0;
         r_bus_out   <= 8'h00;
         r_bus_oe    <= 1'b0;
         r_last_data <= 8'h00;
      end else begin
         r_state   <= w_next;
         r_ready   <= w_ready;
         r_done    <= w_done;
         r_err     <= w_err;
         r_enable  <= w_enable;
         r_write   <= w_write;
         r_bus_out <= w_bus_out;
         r_bus_oe  <= w_bus_oe;
         if (w_accept) begin
            r_src_imm <= bif.src_imm;
            r_src     <= bif.src;
            r_dst     <= bif.dst;
            r_imm     <= bif.imm;
         end
         // Captured on the same edge the destination register loads.
         if (r_state == S_LATCH) r_last_data <= bif.bus_in;
      end
   end

   assign bif.ready     = r_ready;
   assign bif.done      = r_done;
   assign bif.err       = r_err;
   assign bif.enable    = r_enable;
   assign bif.write     = r_write;
   assign bif.bus_out   = r_bus_out;
   assign bif.bus_oe    = r_bus_oe;
   assign bif.last_data = r_last_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_move_ctrl
// Purpose  : Randomized self-checking bench for bus_move_ctrl with a register
//            bank model and transaction-level expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_move_ctrl;
   localparam int NR = 8;
   localparam int SW = 3;
`ifdef BUS_MOVE_CTRL_VERIFY_EN
   localparam int LAT = 4;
   localparam bit VFY = 1'b1;
`else
   localparam int LAT = 3;
   localparam bit VFY = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bus_move_ctrl_if #(.NUM_REGS(NR), .SEL_W(SW)) bif ();

   bus_move_ctrl #(.NUM_REGS(NR), .SEL_W(SW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bif   (bif)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   logic [7:0] bank     [NR];
   logic [7:0] seed     [NR];
   logic [7:0] exp_regs [NR];
   logic [7:0] exp_last;
   logic       load_seed;
   logic       force_bad;

   // Register bank sitting on the bus.
   always @(posedge clk) begin
      for (int k = 0; k < NR; k++) begin
         if (load_seed)          bank[k] <= seed[k];
         else if (bif.write[k])  bank[k] <= bif.bus_in;
      end
   end

   // Bus resolution; force_bad corrupts the readback value.
   always_comb begin
      bif.bus_in = 8'h5A;
      if (bif.bus_oe) bif.bus_in = bif.bus_out;
      else begin
         for (int k = 0; k < NR; k++)
            if (bif.enable[k]) bif.bus_in = bank[k];
      end
      if (force_bad) bif.bus_in = ~bif.bus_in;
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("inv_one_driver", 32'($countones(bif.enable) + int'(bif.bus_oe) <= 1), 32'd1);
         chk("inv_one_write", 32'($countones(bif.write) <= 1), 32'd1);
         chk("inv_write_has_src", 32'((bif.write == '0) || (bif.enable != '0) || bif.bus_oe), 32'd1);
      end
   end

   function automatic logic [7:0] onehot(input int i);
      logic [7:0] one;
      one = 8'd1;
      return one << i;
   endfunction

   function automatic logic [19:0] obs_vec();
      return {bif.ready, bif.done, bif.err, bif.bus_oe, bif.enable, bif.write};
   endfunction

   function automatic logic [19:0] exp_vec(input bit rdy, input bit dn, input bit er,
                                           input bit oe, input logic [7:0] en,
                                           input logic [7:0] wr);
      return {rdy, dn, er, oe, en, wr};
   endfunction

   // One transfer, entered and left on a negedge inside an idle cycle.
   task automatic run_move(input bit im, input logic [2:0] s, input logic [2:0] d,
                           input logic [7:0] v, input bit hold, input bit bad);
      bit         legal;
      logic [7:0] val;
      logic [7:0] src_en;
      int         lat;
      legal  = !((!im && s == d) || (!im && int'(s) >= NR) || int'(d) >= NR);
      val    = im ? v : exp_regs[s];
      lat    = legal ? LAT : 1;
      src_en = im ? 8'h00 : onehot(int'(s));
      bif.req = 1'b1; bif.src_imm = im; bif.src = s; bif.dst = d; bif.imm = v;
      @(negedge clk);
      if (!hold) bif.req = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         if (!legal)
            chk("fail_cycle", 32'(obs_vec()), 32'(exp_vec(0, 1, 1, 0, 8'h00, 8'h00)));
         else if (c == lat)
            chk("done_cycle", 32'(obs_vec()), 32'(exp_vec(0, 1, VFY && bad, 0, 8'h00, 8'h00)));
         else if (c == 3) begin
            chk("verify_cycle", 32'(obs_vec()), 32'(exp_vec(0, 0, 0, 0, onehot(int'(d)), 8'h00)));
            force_bad = bad;
         end else begin
            chk("drive_cycle", 32'(obs_vec()),
                32'(exp_vec(0, 0, 0, im, src_en, (c == 2) ? onehot(int'(d)) : 8'h00)));
            if (im) chk("bus_out", 32'(bif.bus_out), 32'(v));
         end
         @(negedge clk);
         force_bad = 1'b0;
      end
      bif.req = 1'b0;
      if (legal) begin
         exp_regs[d] = val;
         exp_last    = val;
      end
      chk("idle_after", 32'(obs_vec()), 32'(exp_vec(1, 0, 0, 0, 8'h00, 8'h00)));
      chk("last_data", 32'(bif.last_data), 32'(exp_last));
      chk("dst_reg", 32'(bank[d]), 32'(exp_regs[d]));
   endtask

   // Legal register move aborted by reset in cycle rc (1=DRIVE, 2=LATCH).
   task automatic run_reset_mid(input logic [2:0] s, input logic [2:0] d, input int rc);
      bif.req = 1'b1; bif.src_imm = 1'b0; bif.src = s; bif.dst = d; bif.imm = 8'h00;
      @(negedge clk);
      bif.req = 1'b0;
      if (rc == 2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_strobes", 32'(obs_vec()), 32'(exp_vec(1, 0, 0, 0, 8'h00, 8'h00)));
      chk("reset_last", 32'(bif.last_data), 32'd0);
      reset = 1'b0;
      if (rc == 2) exp_regs[d] = exp_regs[s];
      exp_last = 8'h00;
      @(negedge clk);
      chk("after_reset_idle", 32'(obs_vec()), 32'(exp_vec(1, 0, 0, 0, 8'h00, 8'h00)));
      chk("after_reset_dst", 32'(bank[d]), 32'(exp_regs[d]));
   endtask

   initial begin
      reset = 1'b1;
      load_seed = 1'b1;
      force_bad = 1'b0;
      bif.req = 1'b0; bif.src_imm = 1'b0; bif.src = '0; bif.dst = '0; bif.imm = 8'h00;
      for (int k = 0; k < NR; k++) begin
         seed[k]     = 8'($urandom);
         exp_regs[k] = seed[k];
      end
      exp_last = 8'h00;
      repeat (2) @(negedge clk);
      load_seed = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset_idle", 32'(obs_vec()), 32'(exp_vec(1, 0, 0, 0, 8'h00, 8'h00)));
         chk("reset_idle_last", 32'(bif.last_data), 32'd0);
      end

      run_move(1'b1, 3'd0, 3'd2, 8'hA5, 1'b0, 1'b0);
      run_move(1'b0, 3'd2, 3'd5, 8'h00, 1'b0, 1'b0);
      chk("reg5_is_A5", 32'(bank[5]), 32'hA5);
      run_move(1'b0, 3'd3, 3'd3, 8'h00, 1'b0, 1'b0);
      run_move(1'b0, 3'd5, 3'd1, 8'h00, 1'b1, 1'b0);
      run_move(1'b1, 3'd3, 3'd3, 8'h3C, 1'b1, 1'b0);
      run_reset_mid(3'd1, 3'd6, 2);
      run_reset_mid(3'd6, 3'd4, 1);
      if (VFY) begin
         run_move(1'b1, 3'd0, 3'd7, 8'h81, 1'b0, 1'b1);
         run_move(1'b0, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0);
      end

      for (int t = 0; t < 40; t++) begin
         logic [2:0] s;
         logic [2:0] d;
         s = 3'($urandom_range(0, 7));
         d = ($urandom_range(0, 4) == 0) ? s : 3'($urandom_range(0, 7));
         run_move(1'($urandom_range(0, 1)), s, d, 8'($urandom),
                  1'($urandom_range(0, 1)), VFY && ($urandom_range(0, 1) == 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
